// File: rtl/ppu_oam_arbiter.sv
// Primary OAM port arbiter ($2003/$2004 register path, $4014 DMA, sprite evaluator) and OAM DMA sequencer.
// Optional macro PPU_OAMADDR_CLR_EN: oamaddr_clr while rendering clears OAMADDR.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no DMA; CPU owns $2003/$2004
// S_HALT  | CPU halted, waiting one CPU cycle
// S_ALIGN | dummy cycle when the halt ends on an odd CPU cycle
// S_READ  | reading CPU bus at {page, cnt}
// S_WRITE | writing the latched byte into OAM at OAMADDR
module ppu_oam_arbiter #(
    parameter int OAM_AW = 8,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              dma_start,
    input  logic [7:0]        dma_page,
    output logic              cpu_halt,
    output logic              dma_busy,
    output logic [15:0]       dma_bus_addr,
    output logic              dma_bus_rd,
    input  logic [DW-1:0]     dma_bus_data,
    input  logic              reg_oamaddr_we,
    input  logic              reg_oamdata_we,
    input  logic              reg_oamdata_rd,
    input  logic [DW-1:0]     reg_data,
    output logic [DW-1:0]     oamdata_out,
    input  logic              rendering,
    input  logic [OAM_AW-1:0] spr_addr,
    output logic [DW-1:0]     spr_data,
    input  logic              oamaddr_clr,
    output logic [OAM_AW-1:0] oam_addr,
    output logic [DW-1:0]     oam_wdata,
    output logic              oam_we,
    input  logic [DW-1:0]     oam_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                parity_q;
    logic [7:0]          page_q;
    logic [OAM_AW-1:0]   cnt_q;
    logic [OAM_AW-1:0]   oamaddr_q;
    logic [OAM_AW-1:0]   wr_addr_q;
    logic [DW-1:0]       dma_latch_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       oamdata_q;
    logic                we_q;
    logic                rd_pend_q;

    logic                busy;
    logic                bus_rd;
    logic                dma_wr_step;
    logic                cpu_wr_ok;
    logic                oamaddr_inc;
    logic                oamaddr_clr_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dma_start) state_d = S_HALT;
            S_HALT:  if (cpu_ce) state_d = parity_q ? S_ALIGN : S_READ;
            S_ALIGN: if (cpu_ce) state_d = S_READ;
            S_READ:  if (cpu_ce) state_d = S_WRITE;
            S_WRITE: if (cpu_ce) state_d = (cnt_q == {OAM_AW{1'b1}}) ? S_IDLE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        bus_rd      = (state_q == S_READ);
        dma_wr_step = (state_q == S_WRITE) && cpu_ce;
    end

`ifdef PPU_OAMADDR_CLR_EN
    assign oamaddr_clr_hit = oamaddr_clr & rendering;
`else
    logic unused_oamaddr_clr;
    assign unused_oamaddr_clr = oamaddr_clr;
    assign oamaddr_clr_hit    = 1'b0;
`endif

    // $2003 in the same clk takes precedence, so the $2004 write is dropped.
    assign cpu_wr_ok   = reg_oamdata_we && !reg_oamaddr_we && !rendering && !busy;
    assign oamaddr_inc = dma_wr_step || cpu_wr_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q    <= 1'b0;
            page_q      <= '0;
            cnt_q       <= '0;
            oamaddr_q   <= '0;
            wr_addr_q   <= '0;
            dma_latch_q <= '0;
            wdata_q     <= '0;
            oamdata_q   <= '0;
            we_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            if (cpu_ce) begin
                parity_q <= ~parity_q;
            end
            if (state_q == S_IDLE && dma_start) begin
                page_q <= dma_page;
                cnt_q  <= '0;
            end
            if (bus_rd && cpu_ce) begin
                dma_latch_q <= dma_bus_data;
            end
            if (dma_wr_step) begin
                cnt_q <= cnt_q + OAM_AW'(1);
            end

            // Write is issued one clk after the decision so address/data are stable registers.
            we_q <= 1'b0;
            if (dma_wr_step && !rendering) begin
                we_q      <= 1'b1;
                wdata_q   <= dma_latch_q;
                wr_addr_q <= oamaddr_q;
            end else if (cpu_wr_ok) begin
                we_q      <= 1'b1;
                wdata_q   <= reg_data;
                wr_addr_q <= oamaddr_q;
            end

            rd_pend_q <= reg_oamdata_rd;
            if (rd_pend_q) begin
                oamdata_q <= oam_rdata;
            end

            if (oamaddr_clr_hit) begin
                oamaddr_q <= '0;
            end else if (reg_oamaddr_we) begin
                oamaddr_q <= OAM_AW'(reg_data);
            end else if (oamaddr_inc) begin
                oamaddr_q <= oamaddr_q + OAM_AW'(1);
            end
        end
    end

    assign cpu_halt     = busy;
    assign dma_busy     = busy;
    assign dma_bus_rd   = bus_rd;
    assign dma_bus_addr = 16'({page_q, cnt_q});
    assign oamdata_out  = oamdata_q;
    assign spr_data     = oam_rdata;
    assign oam_we       = we_q && !rendering;
    assign oam_wdata    = wdata_q;
    assign oam_addr     = rendering ? spr_addr : (we_q ? wr_addr_q : oamaddr_q);

endmodule
